// File: rtl/data_demultiplexer.sv
// rtl/data_demultiplexer.sv - 3-slot symbol demultiplexer with frame alignment
// Hunts/verifies/locks on frame_start, then routes slots to DS1..DS3 by frame mode.
module data_demultiplexer #(
  parameter int DATA_W      = 3,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  input  logic [DATA_W-1:0] sym_data,
  input  logic              frame_start,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] ds1_data,
  output logic              ds1_valid,
  output logic [DATA_W-1:0] ds2_data,
  output logic              ds2_valid,
  output logic [DATA_W-1:0] ds3_data,
  output logic              ds3_valid,
  output logic              locked,
  output logic              frame_err
);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [2:0] LOCK_N   = 3'(LOCK_FRAMES);

  logic [1:0]        state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [2:0]        good_cnt_q, good_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] ds1_data_q, ds1_data_d;
  logic [DATA_W-1:0] ds2_data_q, ds2_data_d;
  logic [DATA_W-1:0] ds3_data_q, ds3_data_d;
  logic              ds1_valid_q, ds1_valid_d;
  logic              ds2_valid_q, ds2_valid_d;
  logic              ds3_valid_q, ds3_valid_d;
  logic              locked_q, locked_d;
  logic              frame_err_q, frame_err_d;

  logic              expected_start;
  logic [1:0]        next_slot;
  logic              route;
  logic [1:0]        eff_mode;

  assign expected_start = (slot_q == 2'd0);
  assign next_slot      = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
  // Slot 0 is steered by the live mode; later slots use the mode latched at slot 0.
  assign eff_mode       = expected_start ? mode : mode_q;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    good_cnt_d  = good_cnt_q;
    mode_d      = mode_q;
    ds1_data_d  = ds1_data_q;
    ds2_data_d  = ds2_data_q;
    ds3_data_d  = ds3_data_q;
    ds1_valid_d = 1'b0;
    ds2_valid_d = 1'b0;
    ds3_valid_d = 1'b0;
    frame_err_d = 1'b0;
    route       = 1'b0;

    if (sym_valid) begin
      case (state_q)
        S_HUNT: begin
          if (frame_start) begin
            slot_d     = 2'd1;
            good_cnt_d = 3'd1;
            if (LOCK_N == 3'd1) begin
              state_d = S_LOCKED;
              route   = 1'b1;
            end else begin
              state_d = S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          if (expected_start) begin
            if (frame_start) begin
              good_cnt_d = good_cnt_q + 3'd1;
              slot_d     = 2'd1;
              if (good_cnt_d >= LOCK_N) begin
                state_d = S_LOCKED;
                route   = 1'b1;
              end
            end else begin
              state_d    = S_HUNT;
              slot_d     = 2'd0;
              good_cnt_d = 3'd0;
            end
          end else if (frame_start) begin
            slot_d     = 2'd1;
            good_cnt_d = 3'd1;
          end else begin
            slot_d = next_slot;
          end
        end
        S_LOCKED: begin
          if (frame_start == expected_start) begin
            route  = 1'b1;
            slot_d = next_slot;
          end else begin
            frame_err_d = 1'b1;
            if (frame_start) begin
              state_d    = S_VERIFY;
              slot_d     = 2'd1;
              good_cnt_d = 3'd1;
            end else begin
              state_d    = S_HUNT;
              slot_d     = 2'd0;
              good_cnt_d = 3'd0;
            end
          end
        end
        default: begin
          state_d    = S_HUNT;
          slot_d     = 2'd0;
          good_cnt_d = 3'd0;
        end
      endcase
    end

    if (route) begin
      if (expected_start) mode_d = mode;
      if (eff_mode != 2'd0) begin
        if (expected_start || eff_mode == 2'd1 || (slot_q == 2'd2 && eff_mode == 2'd2)) begin
          ds1_valid_d = 1'b1;
          ds1_data_d  = sym_data;
        end else if (slot_q == 2'd1) begin
          ds2_valid_d = 1'b1;
          ds2_data_d  = sym_data;
        end else begin
          ds3_valid_d = 1'b1;
          ds3_data_d  = sym_data;
        end
      end
    end

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      slot_q      <= 2'd0;
      good_cnt_q  <= 3'd0;
      mode_q      <= 2'd0;
      ds1_data_q  <= '0;
      ds2_data_q  <= '0;
      ds3_data_q  <= '0;
      ds1_valid_q <= 1'b0;
      ds2_valid_q <= 1'b0;
      ds3_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      good_cnt_q  <= good_cnt_d;
      mode_q      <= mode_d;
      ds1_data_q  <= ds1_data_d;
      ds2_data_q  <= ds2_data_d;
      ds3_data_q  <= ds3_data_d;
      ds1_valid_q <= ds1_valid_d;
      ds2_valid_q <= ds2_valid_d;
      ds3_valid_q <= ds3_valid_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ds1_data  = ds1_data_q;
  assign ds1_valid = ds1_valid_q;
  assign ds2_data  = ds2_data_q;
  assign ds2_valid = ds2_valid_q;
  assign ds3_data  = ds3_data_q;
  assign ds3_valid = ds3_valid_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_data_demultiplexer.sv
// tb/tb_data_demultiplexer.sv - scoreboard bench for data_demultiplexer
// Reference model tracks alignment per symbol; monitor pops expected output events.
module tb_data_demultiplexer;

  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [2:0] sym_data = 3'd0;
  logic       frame_start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] ds1_data, ds2_data, ds3_data;
  logic       ds1_valid, ds2_valid, ds3_valid;
  logic       locked, frame_err;

  data_demultiplexer #(.DATA_W(3), .LOCK_FRAMES(LOCK)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data),
    .frame_start(frame_start), .mode(mode),
    .ds1_data(ds1_data), .ds1_valid(ds1_valid),
    .ds2_data(ds2_data), .ds2_valid(ds2_valid),
    .ds3_data(ds3_data), .ds3_valid(ds3_valid),
    .locked(locked), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     stream;
    int     data;
    longint cyc;
    bit     lk;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Model: 0 = searching, 1 = confirming, 2 = aligned.
  int m_ph = 0;
  int m_pos = 0;
  int m_run = 0;
  int m_mode = 0;
  int route_tbl[4][3] = '{'{0, 0, 0}, '{1, 1, 1}, '{1, 2, 1}, '{1, 2, 3}};

  task automatic model_reset();
    m_ph = 0; m_pos = 0; m_run = 0; m_mode = 0;
  endtask

  task automatic push_ev(int s, int d);
    ev_t e;
    e.stream = s; e.data = d; e.cyc = cyc + 1; e.lk = (m_ph == 2);
    exp_q.push_back(e);
  endtask

  task automatic model_route(int s, int d, int m);
    if (s == 0) m_mode = m;
    if (route_tbl[m_mode][s] != 0) push_ev(route_tbl[m_mode][s], d);
  endtask

  task automatic model_step(int d, bit fs, int m);
    case (m_ph)
      0: if (fs) begin
        m_run = 1; m_pos = 1;
        if (LOCK == 1) begin m_ph = 2; model_route(0, d, m); end
        else m_ph = 1;
      end
      1: begin
        if (m_pos == 0) begin
          if (fs) begin
            m_run++; m_pos = 1;
            if (m_run >= LOCK) begin m_ph = 2; model_route(0, d, m); end
          end else begin
            m_ph = 0; m_pos = 0;
          end
        end else if (fs) begin
          m_pos = 1; m_run = 1;
        end else begin
          m_pos = (m_pos + 1) % 3;
        end
      end
      default: begin
        if (fs == (m_pos == 0)) begin
          model_route(m_pos, d, m);
          m_pos = (m_pos + 1) % 3;
        end else begin
          if (fs) begin m_ph = 1; m_pos = 1; m_run = 1; end
          else begin m_ph = 0; m_pos = 0; end
          push_ev(0, 0);
        end
      end
    endcase
  endtask

  task automatic send(int d, bit fs, int m, int gap);
    sym_data = 3'(d); frame_start = fs; mode = 2'(m); sym_valid = 1'b1;
    model_step(d, fs, m);
    @(negedge clk);
    sym_valid = 1'b0; frame_start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(int a, int b, int c, int m);
    send(a, 1'b1, m, 0);
    send(b, 1'b0, m, 0);
    send(c, 1'b0, m, 0);
  endtask

  task automatic chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_outputs_zero(string name);
    chk({name, "_outs"}, {ds1_data, ds2_data, ds3_data, ds1_valid, ds2_valid, ds3_valid, locked, frame_err}, 0);
  endtask

  initial begin : monitor
    int nv, gs, gd;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nv = int'(ds1_valid) + int'(ds2_valid) + int'(ds3_valid) + int'(frame_err);
        if (nv > 1) begin
          total++; bad++;
          $display("FAIL multi_strobe at cyc %0d: %0d strobes high, required at most 1", cyc, nv);
        end else if (nv == 1) begin
          gs = ds1_valid ? 1 : ds2_valid ? 2 : ds3_valid ? 3 : 0;
          gd = ds1_valid ? int'(ds1_data) : ds2_valid ? int'(ds2_data) : ds3_valid ? int'(ds3_data) : 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event at cyc %0d: stream %0d data %0d, none expected", cyc, gs, gd);
          end else begin
            e = exp_q.pop_front();
            if (e.stream != gs || e.data != gd || e.cyc != cyc || e.lk != locked) begin
              bad++;
              $display("FAIL event: got stream=%0d data=%0d cyc=%0d locked=%0d expected stream=%0d data=%0d cyc=%0d locked=%0d",
                       gs, gd, cyc, locked, e.stream, e.data, e.cyc, e.lk);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_outputs_zero("reset");

    // clean lock
    send_frame(1, 2, 3, 3);
    chk("locked_after_f1", locked, (m_ph == 2));
    send_frame(1, 2, 3, 3);
    chk("locked_after_f2", locked, (m_ph == 2));
    send_frame(1, 2, 3, 3);

    // mode patterns
    send_frame(5, 6, 7, 1);
    send_frame(5, 6, 7, 2);
    send_frame(5, 6, 7, 0);
    send_frame(4, 2, 6, 3);

    // mid-frame mode change
    send(1, 1'b1, 3, 0);
    send(2, 1'b0, 1, 0);
    send(3, 1'b0, 1, 0);
    send_frame(4, 5, 6, 1);

    // misplaced frame_start, then relock
    send(1, 1'b1, 3, 0);
    send(2, 1'b1, 3, 0);
    chk("locked_after_misplaced", locked, (m_ph == 2));
    send(3, 1'b0, 3, 0);
    send(4, 1'b0, 3, 0);
    send_frame(1, 2, 3, 3);
    send_frame(5, 6, 7, 3);
    chk("relocked", locked, (m_ph == 2));

    // missing frame_start
    send(1, 1'b0, 3, 0);
    chk("locked_after_missing", locked, (m_ph == 2));
    send_frame(1, 2, 3, 3);
    send_frame(1, 2, 3, 3);
    chk("locked_after_hunt", locked, (m_ph == 2));

    // reset mid-frame with sym_valid high
    send(7, 1'b1, 3, 0);
    rst = 1'b1; sym_valid = 1'b1; sym_data = 3'd5; frame_start = 1'b0;
    @(negedge clk);
    rst = 1'b0; sym_valid = 1'b0;
    model_reset();
    chk_outputs_zero("mid_reset");
    @(negedge clk);
    chk_outputs_zero("mid_reset_hold");

    // randomized stream with gaps
    for (int i = 0; i < 600; i++) begin
      int d, m, g;
      bit fs;
      d = $urandom_range(0, 7);
      m = $urandom_range(0, 3);
      g = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(0, 5);
      if ($urandom_range(0, 19) == 0) fs = 1'($urandom_range(0, 1));
      else fs = (m_pos == 0);
      send(d, fs, m, g);
    end
    chk("locked_end", locked, (m_ph == 2));

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_demultiplexer.md
Name: data_demultiplexer

Overview:
- Receive-side counterpart of the 3-slot data multiplexer.
- Takes the received multiplexed symbol stream, one 3-bit symbol per slot and three slots per frame, and finds frame alignment from a frame-start marker.
- Routes each slot back to stream DS1, DS2 or DS3 according to the frame's mode pattern, with per-stream valid strobes.
- Sits after the symbol-timing recovery in the clk domain; symbols arrive as single-cycle enables.

Parameters:
DATA_W, 3, width of one symbol and of each stream output
LOCK_FRAMES, 2, consecutive correctly placed frame starts needed to declare lock (legal range 1..7)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous active-high reset
sym_valid  input  1  one-cycle strobe: sym_data and frame_start are valid this cycle
sym_data  input  DATA_W  received symbol
frame_start  input  1  qualified by sym_valid; marks slot 0 of a frame
mode  input  2  routing pattern; sampled only on an accepted slot-0 symbol
ds1_data  output  DATA_W  last symbol routed to DS1
ds1_valid  output  1  one-cycle strobe for ds1_data
ds2_data  output  DATA_W  last symbol routed to DS2
ds2_valid  output  1  one-cycle strobe for ds2_data
ds3_data  output  DATA_W  last symbol routed to DS3
ds3_valid  output  1  one-cycle strobe for ds3_data
locked  output  1  high while in LOCKED
frame_err  output  1  one-cycle pulse on an alignment error while LOCKED

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs go to 0.
  - State=HUNT; slot=0; good_cnt=0; mode_q=0.
  - Reset overrides everything, including a sym_valid in the same cycle; no output strobe results.
- Only cycles with sym_valid=1 advance state. Other cycles hold all state; all valid strobes and frame_err are 0.
- Slot counter: 0→1→2→0, advancing on each sym_valid. expected_start = (slot==0).
- HUNT:
  - sym_valid & frame_start → VERIFY, slot=1, good_cnt=1.
  - If LOCK_FRAMES==1, go directly to LOCKED instead, and route this symbol.
  - Any other symbol is discarded.
- VERIFY:
  - Each symbol advances the slot.
  - Slot 0 with frame_start → good_cnt+1. Reaching LOCK_FRAMES → LOCKED, and this symbol is routed.
  - frame_start not at slot 0 → restart VERIFY: slot=1, good_cnt=1.
  - Slot 0 without frame_start → HUNT.
  - No symbols are routed in VERIFY.
- LOCKED:
  - Good symbol (frame_start==expected_start) → routed, slot advances.
  - Mismatch (missing or misplaced frame_start):
    - frame_err=1 for one cycle, locked drops the next cycle, symbol not routed.
    - If frame_start=1 → VERIFY, slot=1, good_cnt=1; otherwise → HUNT.
- Mode latch:
  - mode_q<=mode on every slot-0 symbol that is routed or that enters LOCKED.
  - The same-cycle mode value governs that slot-0 symbol.
  - Mode changes mid-frame have no effect until the next frame.
- Routing of a routed symbol by (mode, slot):
  - mode 1: slots 0,1,2 → DS1.
  - mode 2: slot 0 → DS1, slot 1 → DS2, slot 2 → DS1.
  - mode 3: slot 0 → DS1, slot 1 → DS2, slot 2 → DS3.
  - mode 0: discard; no strobes, slot still advances.
- Latency: dsN_data/dsN_valid are registered and appear exactly 1 clk after the sym_valid cycle.
  - At most one dsN_valid is high per cycle.
  - dsN_data holds its last value when not strobed.
- locked is registered and reflects the state after the transition, so it rises 1 clk after the locking symbol.
- Back-to-back sym_valid on every clk is supported at full rate.

Test Plan:
- Reset then clean lock: rst 2 cycles; frames with mode=3 and symbols {1,2,3} with frame_start on the 1st symbol, sent 3 times, back-to-back → nothing routed in frame 1. Frame 2 slot 0 locks. Outputs: ds1=1, ds2=2, ds3=3 strobes, then frame 3 repeats; locked=1 from frame 2.
- Mode patterns once locked: mode=1 with {5,6,7} → ds1_valid three times with data 5,6,7. mode=2 with {5,6,7} → ds1=5, ds2=6, ds1=7. mode=0 → no strobes; next frame with mode=3 routes normally.
- Mid-frame mode change: mode=3 at slot 0, mode=1 at slots 1/2 → routing stays ds1, ds2, ds3 for that frame; the next frame uses mode=1.
- Misplaced frame_start while LOCKED: frame_start at slot 1 → frame_err pulse, no strobe, locked=0. Followed by 2 good frames (LOCK_FRAMES=2) → relock on slot 0 of the next frame.
- Missing frame_start at slot 0 while LOCKED → frame_err, HUNT; the next frame_start restarts VERIFY.
- Gaps and reset: sym_valid gaps of 0–5 idle cycles between symbols → identical routing with 1-clk latency. rst asserted mid-frame with sym_valid=1 → all outputs 0 next cycle, HUNT, no strobe.
